// File: rtl/xbtn_debounce_pkg.sv
// Shared definitions for the push-button conditioner: state encodings and default sizing.
// The auto-repeat feature is enabled by defining BTN_AUTOREPEAT_EN.
package xbtn_debounce_pkg;

   localparam int unsigned NBtnDefault     = 3;
   localparam int unsigned DebounceDefault = 500000;
   localparam int unsigned CntWDefault     = 20;
   localparam int unsigned HoldDefault     = 25000000;
   localparam int unsigned RepeatDefault   = 5000000;

   typedef enum logic [1:0] {
      StIdle        = 2'd0,
      StPressWait   = 2'd1,
      StPressed     = 2'd2,
      StReleaseWait = 2'd3
   } btn_state_e;

endpackage

// File: rtl/xbtn_debounce_chan.sv
// One button channel: 2-flop synchroniser, debounce FSM and counter.
// With BTN_AUTOREPEAT_EN defined, a repeat counter adds extra events while held.
module xbtn_debounce_chan
   import xbtn_debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DebounceDefault,
   parameter int unsigned CNT_W           = CntWDefault,
   parameter int unsigned HOLD_CYCLES     = HoldDefault,
   parameter int unsigned REPEAT_CYCLES   = RepeatDefault
) (
   input  logic clk,
   input  logic rst,
   input  logic pshbtn,
   output logic lvl,
   output logic press_evt
);

   // The wait state is left on the edge where the count reaches DEBOUNCE_CYCLES-1,
   // so the decision is taken while the count still holds DEBOUNCE_CYCLES-2.
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 2);

   logic             sync1_q, sync2_q;
   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lvl_q, lvl_d;
   logic             fsm_evt;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fsm_evt = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (sync2_q) begin
               state_d = StPressWait;
               cnt_d   = '0;
            end
         end
         StPressWait: begin
            if (!sync2_q) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntLast) begin
                  state_d = StPressed;
                  fsm_evt = 1'b1;
               end
            end
         end
         StPressed: begin
            if (!sync2_q) begin
               state_d = StReleaseWait;
               cnt_d   = '0;
            end
         end
         StReleaseWait: begin
            if (sync2_q) begin
               state_d = StPressed;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntLast) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      lvl_d = (state_d == StPressed) || (state_d == StReleaseWait);
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int unsigned RepMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int unsigned RcntW  = $clog2(RepMax + 1);

   logic [RcntW-1:0] rcnt_q, rcnt_d;
   logic             rep_phase_q, rep_phase_d;
   logic             rep_evt;

   // rep_phase_q: 0 while waiting out the initial hold, 1 once repeating.
   always_comb begin
      rcnt_d      = '0;
      rep_phase_d = 1'b0;
      rep_evt     = 1'b0;
      if (state_q == StPressed) begin
         rep_phase_d = rep_phase_q;
         if (rcnt_q == (rep_phase_q ? RcntW'(REPEAT_CYCLES - 1) : RcntW'(HOLD_CYCLES - 1))) begin
            rep_evt     = 1'b1;
            rep_phase_d = 1'b1;
         end else begin
            rcnt_d = rcnt_q + 1'b1;
         end
      end
   end

   assign press_evt = fsm_evt | rep_evt;
`else
   assign press_evt = fsm_evt;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         state_q     <= StIdle;
         cnt_q       <= '0;
         lvl_q       <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rcnt_q      <= '0;
         rep_phase_q <= 1'b0;
`endif
      end else begin
         sync1_q     <= pshbtn;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lvl_q       <= lvl_d;
`ifdef BTN_AUTOREPEAT_EN
         rcnt_q      <= rcnt_d;
         rep_phase_q <= rep_phase_d;
`endif
      end
   end

   assign lvl = lvl_q;

endmodule

// File: rtl/xbtn_debounce.sv
// Push-button conditioner: per-button debounce channels feeding a sticky, read-cleared latch.
// Optional auto-repeat per channel is enabled by defining BTN_AUTOREPEAT_EN.
module xbtn_debounce
   import xbtn_debounce_pkg::*;
#(
   parameter int unsigned N_BTN           = NBtnDefault,
   parameter int unsigned DEBOUNCE_CYCLES = DebounceDefault,
   parameter int unsigned CNT_W           = CntWDefault,
   parameter int unsigned HOLD_CYCLES     = HoldDefault,
   parameter int unsigned REPEAT_CYCLES   = RepeatDefault
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] pshbtn,
   input  logic             sel,
   input  logic             we,
   output logic [N_BTN-1:0] btn_rd,
   output logic [N_BTN-1:0] btn_lvl,
   output logic             btn_irq
);

   logic [N_BTN-1:0] press_evt;
   logic [N_BTN-1:0] btn_rd_q, btn_rd_d;
   logic             rd_clr;

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      xbtn_debounce_chan #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W),
         .HOLD_CYCLES    (HOLD_CYCLES),
         .REPEAT_CYCLES  (REPEAT_CYCLES)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .pshbtn   (pshbtn[i]),
         .lvl      (btn_lvl[i]),
         .press_evt(press_evt[i])
      );
   end

   // A new event outranks a concurrent read-clear on its own bit.
   always_comb begin
      rd_clr   = sel & ~we;
      btn_rd_d = (rd_clr ? '0 : btn_rd_q) | press_evt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) btn_rd_q <= '0;
      else     btn_rd_q <= btn_rd_d;
   end

   assign btn_rd  = btn_rd_q;
   assign btn_irq = |btn_rd_q;

endmodule

// File: tb/tb_xbtn_debounce.sv
// Self-checking bench for xbtn_debounce against a run-length reference model.
// Define BTN_AUTOREPEAT_EN on both bench and RTL to exercise auto-repeat.
module tb_xbtn_debounce;

   localparam int NB  = 3;
   localparam int DB  = 4;
   localparam int HLD = 10;
   localparam int REP = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] pshbtn = '0;
   logic          sel = 1'b0;
   logic          we = 1'b0;
   logic [NB-1:0] btn_rd, btn_lvl;
   logic          btn_irq;

   int n_cmp = 0;
   int n_fail = 0;

   xbtn_debounce #(
      .N_BTN          (NB),
      .DEBOUNCE_CYCLES(DB),
      .CNT_W          (4),
      .HOLD_CYCLES    (HLD),
      .REPEAT_CYCLES  (REP)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .pshbtn (pshbtn),
      .sel    (sel),
      .we     (we),
      .btn_rd (btn_rd),
      .btn_lvl(btn_lvl),
      .btn_irq(btn_irq)
   );

   always #5 clk = ~clk;

   // Reference model: level flips once DB consecutive synchronised samples disagree with it.
   bit [NB-1:0] m_s1, m_s2, m_lvl, m_rd;
   int          m_run [NB];
   int          m_hold[NB];

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rd = '0;
      for (int i = 0; i < NB; i++) begin
         m_run[i]  = 0;
         m_hold[i] = 0;
      end
   endtask

   task automatic model_edge();
      bit [NB-1:0] evt;
      evt = '0;
      if (rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < NB; i++) begin
         bit held_stable;
         int run_incl;
         held_stable = m_lvl[i] && (m_run[i] == 0);
         run_incl    = (m_s2[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
`ifdef BTN_AUTOREPEAT_EN
         if (held_stable) begin
            m_hold[i]++;
            if (m_hold[i] >= HLD && ((m_hold[i] - HLD) % REP) == 0) evt[i] = 1'b1;
         end else begin
            m_hold[i] = 0;
         end
`else
         if (held_stable) m_hold[i] = 0;
`endif
         if (run_incl >= DB) begin
            m_lvl[i] = ~m_lvl[i];
            if (m_lvl[i]) evt[i] = 1'b1;
            m_run[i] = 0;
         end else begin
            m_run[i] = run_incl;
         end
      end
      m_rd = ((sel && !we) ? '0 : m_rd) | evt;
      m_s2 = m_s1;
      m_s1 = pshbtn;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_model();
      check("rd",  32'(btn_rd),  32'(m_rd));
      check("lvl", 32'(btn_lvl), 32'(m_lvl));
      check("irq", 32'(btn_irq), 32'(|m_rd));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   int got_ev[$];
   int exp_ev[$];

   initial begin
      model_reset();
      #1;

      // Reset held while the pins toggle.
      for (int k = 0; k < 6; k++) begin
         pshbtn = NB'($urandom);
         step();
         check("rst_rd", 32'(btn_rd), 32'd0);
         check("rst_lvl", 32'(btn_lvl), 32'd0);
      end
      pshbtn = '0;
      step();
      rst = 1'b0;
      steps(8);
      check("post_rst_irq", 32'(btn_irq), 32'd0);

      // Clean press on button 0: visible exactly 6 cycles after the edge.
      pshbtn = 3'b001;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 5) check("press_early", 32'(btn_rd), 32'd0);
         if (k == 6) begin
            check("press_rd", 32'(btn_rd), 32'b001);
            check("press_lvl", 32'(btn_lvl[0]), 32'd1);
            check("press_irq", 32'(btn_irq), 32'd1);
         end
      end

      // Bounce on button 1 never qualifies.
      for (int r = 0; r < 4; r++) begin
         pshbtn[1] = 1'b1;
         for (int k = 0; k < 3; k++) begin
            step();
            check("bounce_lvl", 32'(btn_lvl[1]), 32'd0);
            check("bounce_rd", 32'(btn_rd[1]), 32'd0);
         end
         pshbtn[1] = 1'b0;
         for (int k = 0; k < 3; k++) begin
            step();
            check("bounce_lvl", 32'(btn_lvl[1]), 32'd0);
            check("bounce_rd", 32'(btn_rd[1]), 32'd0);
         end
      end

      // Writes are ignored, reads clear.
      sel = 1'b1; we = 1'b1;
      step();
      check("write_keep", 32'(btn_rd), 32'b001);
      we = 1'b0;
      step();
      check("read_clr", 32'(btn_rd), 32'd0);
      sel = 1'b0;
      pshbtn = '0;
      steps(10);

      // Simultaneous read and new event on button 2.
      pshbtn = 3'b001;
      steps(7);
      check("sim_pre", 32'(btn_rd), 32'b001);
      pshbtn = 3'b101;
      steps(5);
      sel = 1'b1; we = 1'b0;
      step();
      check("sim_set_wins", 32'(btn_rd), 32'b100);
      sel = 1'b0;
      pshbtn = '0;
      steps(12);
      sel = 1'b1;
      step();
      sel = 1'b0;

      // Long hold with a read every cycle.
`ifdef BTN_AUTOREPEAT_EN
      exp_ev = '{6, 16, 21, 26, 31, 36};
`else
      exp_ev = '{6};
`endif
      pshbtn = 3'b001;
      sel = 1'b1; we = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (btn_rd[0]) got_ev.push_back(k);
      end
      check("rep_count", 32'(got_ev.size()), 32'(exp_ev.size()));
      for (int j = 0; j < exp_ev.size() && j < got_ev.size(); j++)
         check("rep_time", 32'(got_ev[j]), 32'(exp_ev[j]));
      sel = 1'b0;
      pshbtn = '0;
      steps(12);

      // Reset asserted mid-count drops the pending press immediately.
      pshbtn = 3'b010;
      steps(4);
      rst = 1'b1;
      #1;
      model_reset();
      check("midrst_rd", 32'(btn_rd), 32'd0);
      check("midrst_lvl", 32'(btn_lvl), 32'd0);
      steps(2);
      rst = 1'b0;
      steps(10);

      // Randomised traffic, run lengths mixing bounces and clean presses.
      for (int k = 0; k < 800; k++) begin
         for (int i = 0; i < NB; i++)
            if ($urandom_range(5) == 0) pshbtn[i] = ~pshbtn[i];
         sel = ($urandom_range(3) == 0);
         we  = $urandom_range(1) == 1;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
